// File: rtl/fp_addsub_scheduler.sv
// Shares one fixed-latency FP add/sub datapath among NUM_REQ requesters:
// round-robin issue, tag pipeline, in-order result FIFO and run/drain/halt control.
module fp_addsub_scheduler #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DP_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0]         req_op,
  input  logic                       hold,
  output logic [WIDTH-1:0]           dp_a,
  output logic [WIDTH-1:0]           dp_b,
  output logic                       dp_valid,
  input  logic [WIDTH-1:0]           dp_result,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [WIDTH-1:0]           resp_data,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic                       halted
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + DP_LAT + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   cand;
  logic              grant_found;
  logic              issue_ok;
  logic              transfer;
  logic [WIDTH-1:0]  dp_a_q;
  logic [WIDTH-1:0]  dp_b_q;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  tag_t [DP_LAT-1:0] tags;
  logic [OCC_W-1:0]  inflight;
  logic [OCC_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [WIDTH-1:0]  mem_data [FIFO_DEPTH];
  logic [ID_W-1:0]   mem_id   [FIFO_DEPTH];
  logic              push;
  logic              pop;

  // Occupancy of the datapath: one per valid tag stage.
  always_comb begin
    inflight = '0;
    for (int unsigned k = 0; k < DP_LAT; k++) begin
      inflight = inflight + OCC_W'(tags[k].valid);
    end
  end

  // Reserving a FIFO slot per in-flight op makes overflow impossible.
  assign issue_ok = reset && (state == ST_RUN) && !hold &&
                    ((fifo_count + inflight) < OCC_W'(FIFO_DEPTH));

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = ID_W'((32'(last_grant) + off) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign transfer  = issue_ok && grant_found;
  assign req_ready = transfer ? (NUM_REQ'(1) << grant_id) : '0;

  // Subtraction is an add with the second operand's sign flipped.
  assign sel_a    = req_a[grant_id*WIDTH +: WIDTH];
  assign sel_b    = req_b[grant_id*WIDTH +: WIDTH] ^ {req_op[grant_id], {(WIDTH-1){1'b0}}};
  assign dp_valid = transfer;
  assign dp_a     = transfer ? sel_a : dp_a_q;
  assign dp_b     = transfer ? sel_b : dp_b_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      dp_a_q     <= '0;
      dp_b_q     <= '0;
      tags       <= '0;
    end else begin
      if (transfer) begin
        last_grant <= grant_id;
        dp_a_q     <= sel_a;
        dp_b_q     <= sel_b;
      end
      tags[0] <= tag_t'{valid: transfer, id: grant_id};
      for (int unsigned k = 1; k < DP_LAT; k++) begin
        tags[k] <= tags[k-1];
      end
    end
  end

  assign push = tags[DP_LAT-1].valid;
  assign pop  = resp_valid && resp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + OCC_W'(1);
        2'b01:   fifo_count <= fifo_count - OCC_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: the output is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= dp_result;
      mem_id[wr_ptr]   <= tags[DP_LAT-1].id;
    end
  end

  assign resp_valid = (fifo_count != '0);
  assign resp_data  = resp_valid ? mem_data[rd_ptr] : '0;
  assign resp_id    = resp_valid ? mem_id[rd_ptr]   : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hold) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!hold) begin
            state <= ST_RUN;
          end else if ((inflight == '0) && (fifo_count == '0)) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (!hold) begin
            state  <= ST_RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_scheduler.sv
// Bench for fp_addsub_scheduler: queue-based reference model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_fp_addsub_scheduler;

  localparam int W = 32;
  localparam int N = 4;
  localparam int L = 1;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_op;
  logic           hold;
  logic [W-1:0]   dp_a;
  logic [W-1:0]   dp_b;
  logic           dp_valid;
  logic [W-1:0]   dp_result;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_data;
  logic [1:0]     resp_id;
  logic           halted;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_a[g*W +: W] = op_a[g];
    assign req_b[g*W +: W] = op_b[g];
  end

  fp_addsub_scheduler #(.WIDTH(W), .NUM_REQ(N), .DP_LAT(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .hold(hold),
    .dp_a(dp_a), .dp_b(dp_b), .dp_valid(dp_valid), .dp_result(dp_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .halted(halted)
  );

  // Simple datapath model: integer sum of the raw bit patterns, one cycle late.
  always @(posedge clk) dp_result <= dp_valid ? (dp_a + dp_b) : 32'hDEAD_BEEF;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: ops in flight, results queued, round-robin pointer, mode.
  typedef struct { int id; int rem; logic [31:0] res; } fl_t;
  typedef struct { logic [31:0] d; int id; } fe_t;

  fl_t          fl_q[$];
  fe_t          ff_q[$];
  fl_t          fl_new;
  fe_t          fe_new;
  int           m_last = N - 1;
  int           m_mode = 0;
  int           m_pick;
  int           m_j;
  bit           m_issue;
  bit           m_drained;
  logic [31:0]  m_da = '0;
  logic [31:0]  m_db = '0;
  logic [31:0]  e_a;
  logic [31:0]  e_b;
  logic [N-1:0] e_ready;

  always @(negedge clk) begin
    if (!reset) begin
      fl_q.delete();
      ff_q.delete();
      m_last = N - 1;
      m_mode = 0;
      m_da   = '0;
      m_db   = '0;
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_dp_valid", 32'(dp_valid), 32'h0);
      check("rst_dp_a", dp_a, 32'h0);
      check("rst_dp_b", dp_b, 32'h0);
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_resp_data", resp_data, 32'h0);
      check("rst_resp_id", 32'(resp_id), 32'h0);
      check("rst_halted", 32'(halted), 32'h0);
    end else begin
      m_pick = -1;
      for (int off = 1; off <= N; off++) begin
        m_j = (m_last + off) % N;
        if (m_pick < 0 && req_valid[m_j[1:0]]) m_pick = m_j;
      end
      m_issue = (m_mode == 0) && !hold && (ff_q.size() + fl_q.size() < D) && (m_pick >= 0);
      e_ready = m_issue ? (N'(1) << m_pick) : '0;
      e_a = m_issue ? op_a[m_pick] : m_da;
      e_b = m_issue ? (op_b[m_pick] ^ {req_op[m_pick], 31'b0}) : m_db;

      check("m_req_ready", 32'(req_ready), 32'(e_ready));
      check("m_dp_valid", 32'(dp_valid), 32'(m_issue));
      check("m_dp_a", dp_a, e_a);
      check("m_dp_b", dp_b, e_b);
      check("m_resp_valid", 32'(resp_valid), 32'(ff_q.size() > 0));
      check("m_resp_data", resp_data, (ff_q.size() > 0) ? ff_q[0].d : 32'h0);
      check("m_resp_id", 32'(resp_id), (ff_q.size() > 0) ? 32'(ff_q[0].id) : 32'h0);
      check("m_halted", 32'(halted), 32'(m_mode == 2));

      // Advance to the next cycle.
      m_drained = (fl_q.size() == 0) && (ff_q.size() == 0);
      if (m_mode == 0 && hold) m_mode = 1;
      else if (m_mode == 1) m_mode = !hold ? 0 : (m_drained ? 2 : 1);
      else if (m_mode == 2 && !hold) m_mode = 0;

      if (ff_q.size() > 0 && resp_ready) void'(ff_q.pop_front());
      while (fl_q.size() > 0 && fl_q[0].rem == 1) begin
        fe_new.d  = fl_q[0].res;
        fe_new.id = fl_q[0].id;
        ff_q.push_back(fe_new);
        void'(fl_q.pop_front());
      end
      foreach (fl_q[k]) fl_q[k].rem--;
      if (m_issue) begin
        fl_new.id  = m_pick;
        fl_new.rem = L;
        fl_new.res = e_a + e_b;
        fl_q.push_back(fl_new);
        m_last = m_pick;
        m_da   = e_a;
        m_db   = e_b;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    reset      = 1'b0;
    req_valid  = '0;
    req_op     = '0;
    hold       = 1'b0;
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    check("reset_masks_ready", 32'(req_ready), 32'h0);
    check("reset_no_resp", 32'(resp_valid), 32'h0);
    req_valid = '0;
    step();

    // Round-robin with every requester valid; responses follow two cycles later.
    for (int i = 0; i < N; i++) begin
      op_a[i] = 32'h1000_0000 * (i + 1);
      op_b[i] = 32'(i + 5);
    end
    req_op     = 4'b1010;
    reset      = 1'b1;
    resp_ready = 1'b1;
    req_valid  = '1;
    for (int c = 0; c < 7; c++) begin
      #2;
      check("rr_grant", 32'(req_ready), 32'(1) << (c % 4));
      if (c >= 2) begin
        check("rr_resp_valid", 32'(resp_valid), 32'h1);
        check("rr_resp_id", 32'(resp_id), 32'((c - 2) % 4));
      end
      step();
    end
    req_valid = '0;
    repeat (3) step();

    // Subtract on requester 2: sign of b flips before the datapath.
    op_a[2]   = 32'h3F80_0000;
    op_b[2]   = 32'h4000_0000;
    req_op    = 4'b0100;
    req_valid = 4'b0100;
    #2;
    check("sub_dp_valid", 32'(dp_valid), 32'h1);
    check("sub_dp_a", dp_a, 32'h3F80_0000);
    check("sub_dp_b", dp_b, 32'hC000_0000);
    check("sub_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    step();
    #2;
    check("sub_resp_valid", 32'(resp_valid), 32'h1);
    check("sub_resp_id", 32'(resp_id), 32'h2);
    check("sub_resp_data", resp_data, 32'hFF80_0000);
    repeat (3) step();

    // Backpressure: FIFO depth caps the number of outstanding transfers.
    resp_ready = 1'b0;
    req_op     = '0;
    op_a[0]    = 32'h0000_0100;
    op_b[0]    = 32'h0000_0011;
    req_valid  = 4'b0001;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      #2;
      if (req_ready[0]) cnt++;
      step();
    end
    check("fill_transfers", 32'(cnt), 32'h4);
    #2;
    check("full_ready", 32'(req_ready), 32'h0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      #2;
      if (req_ready[0]) cnt++;
      step();
    end
    check("refill_transfers", 32'(cnt), 32'h1);
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (6) step();

    // Drain and halt with one op in flight and two results queued.
    resp_ready = 1'b0;
    op_a[1]    = 32'h4040_0000;
    op_b[1]    = 32'h3F80_0000;
    req_op     = 4'b0010;
    req_valid  = 4'b0010;
    repeat (3) step();
    hold = 1'b1;
    #2;
    check("hold_no_grant", 32'(req_ready), 32'h0);
    check("hold_queued", 32'(resp_valid), 32'h1);
    step();
    resp_ready = 1'b1;
    for (int i = 0; i < 12 && !halted; i++) step();
    #2;
    check("halted_rise", 32'(halted), 32'h1);
    check("halted_empty", 32'(resp_valid), 32'h0);
    check("halted_no_grant", 32'(req_ready), 32'h0);
    hold = 1'b0;
    #1;
    check("resume_wait", 32'(req_ready), 32'h0);
    step();
    #2;
    check("resume_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    repeat (4) step();

    // Reset mid-operation discards in-flight and queued results.
    resp_ready = 1'b0;
    req_op     = '0;
    op_a[3]    = 32'h1111_1111;
    op_b[3]    = 32'h2222_2222;
    req_valid  = 4'b1000;
    repeat (4) step();
    req_valid = '0;
    #2;
    check("pre_rst_queued", 32'(resp_valid), 32'h1);
    reset = 1'b0;
    #1;
    check("rst_mid_valid", 32'(resp_valid), 32'h0);
    check("rst_mid_data", resp_data, 32'h0);
    step();
    step();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      check("post_rst_empty", 32'(resp_valid), 32'h0);
      step();
    end
    op_a[0]   = 32'h0000_0A00;
    op_b[0]   = 32'h0000_00B0;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    #2;
    check("post_rst_resp", 32'(resp_valid), 32'h1);
    check("post_rst_id", 32'(resp_id), 32'h0);
    check("post_rst_data", resp_data, 32'h0000_0AB0);
    resp_ready = 1'b1;
    repeat (3) step();

    // Simultaneous push and pop with a single entry queued.
    resp_ready = 1'b0;
    op_b[2]    = 32'h0000_0001;
    op_a[2]    = 32'h1234_0000;
    req_valid  = 4'b0100;
    step();
    op_a[2] = 32'h5678_0000;
    step();
    req_valid  = '0;
    resp_ready = 1'b1;
    #2;
    check("pp_first", resp_data, 32'h1234_0001);
    step();
    resp_ready = 1'b0;
    #2;
    check("pp_valid", 32'(resp_valid), 32'h1);
    check("pp_second", resp_data, 32'h5678_0001);
    check("pp_id", 32'(resp_id), 32'h2);
    step();
    #2;
    check("pp_stable", resp_data, 32'h5678_0001);
    resp_ready = 1'b1;
    step();
    #2;
    check("pp_count_one", 32'(resp_valid), 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_addsub_scheduler.md
FP_ADDSUB_SCHEDULER -- requirements
Module: fp_addsub_scheduler

Interface
REQ-001 Parameter WIDTH, default 32, IEEE 754 operand/result width.
REQ-002 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 Parameter DP_LAT, default 1, fixed latency of the shared add/sub datapath in cycles (1..4).
REQ-004 Parameter FIFO_DEPTH, default 4, result FIFO entries (power of 2, >= DP_LAT+1).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 req_valid  input  NUM_REQ  per-requester operation valid.
REQ-008 req_ready  output  NUM_REQ  per-requester grant; one-hot or zero.
REQ-009 req_a, req_b  input  NUM_REQ*WIDTH  packed operands; requester i at bits [i*WIDTH +: WIDTH].
REQ-010 req_op  input  NUM_REQ  per-requester op: 0 = a+b, 1 = a-b.
REQ-011 hold  input  1  drain request: stop granting, finish in-flight work.
REQ-012 dp_a, dp_b  output  WIDTH  operands to shared datapath.
REQ-013 dp_valid  output  1  datapath issue strobe.
REQ-014 dp_result  input  WIDTH  datapath result, valid DP_LAT cycles after dp_valid.
REQ-015 resp_valid, resp_ready  output/input  1  result handshake.
REQ-016 resp_data  output  WIDTH  result at FIFO head.
REQ-017 resp_id  output  clog2(NUM_REQ)  requester index of resp_data.
REQ-018 halted  output  1  high in HALTED state.

Function
REQ-019 Transfer on requester i occurs when req_valid[i] && req_ready[i]; at most one per cycle.
REQ-020 Issue permitted when state==RUN and (fifo_count + inflight) < FIFO_DEPTH.
REQ-021 Grant: round-robin among valid requesters, starting at index (last_grant+1) mod NUM_REQ; last_grant updates only on a transfer.
REQ-022 req_ready is combinational from req_valid, pointer and issue permission; never asserted to a non-valid requester.
REQ-023 On transfer: dp_valid=1, dp_a=req_a[i], dp_b=req_b[i] with sign bit (WIDTH-1) inverted when req_op[i]=1; same cycle, no register.
REQ-024 When not issuing, dp_valid=0 and dp_a/dp_b hold last issued values.
REQ-025 Tag pipeline: DP_LAT-stage shift register of {valid, id}; stage DP_LAT output valid writes dp_result and id into the FIFO that cycle.
REQ-026 inflight = count of valid tag stages, 0..DP_LAT.
REQ-027 FIFO: resp_valid = (fifo_count != 0); pop on resp_valid && resp_ready; simultaneous push and pop leaves count unchanged; pop of the last entry with a push in the same cycle keeps resp_valid high.
REQ-028 FIFO overflow is impossible by REQ-020; pointers wrap modulo FIFO_DEPTH.
REQ-029 FSM states: RUN, DRAIN, HALTED.
REQ-030 RUN -> DRAIN when hold=1; no grant in the cycle hold is sampled high.
REQ-031 DRAIN -> HALTED when inflight==0 and fifo_count==0; DRAIN -> RUN if hold drops first.
REQ-032 HALTED -> RUN when hold=0; FIFO continues to drain and respond in every state.

Reset
REQ-033 Asserted reset: state=RUN, req_ready=0, dp_valid=0, dp_a=dp_b=0, tag pipeline cleared, FIFO empty, resp_valid=0, resp_data=0, resp_id=0, halted=0, last_grant=NUM_REQ-1 (requester 0 highest first priority).
REQ-034 Reset mid-operation discards in-flight tags and FIFO contents; late dp_result is ignored.
REQ-035 Deassertion is synchronized externally; first grant is possible in the first clock after release.

Verification
REQ-036 All four requesters valid continuously, resp_ready=1 -> grants cycle 0,1,2,3,0; resp_id follows the same order, each DP_LAT+1 cycles after issue.
REQ-037 Requester 2, req_a=0x3F800000, req_b=0x40000000, req_op=1 -> dp_b=0xC0000000, dp_valid=1, resp_id=2.
REQ-038 resp_ready=0, requester 0 always valid, DP_LAT=1, FIFO_DEPTH=4 -> exactly 4 transfers, then req_ready=0 until a pop; each pop allows one further grant.
REQ-039 hold=1 with 1 in flight and 2 queued -> no grants, halted rises the cycle after the third pop; hold=0 -> RUN, grants resume next cycle.
REQ-040 Reset pulled low with a result in flight and 3 queued -> resp_valid=0 immediately, no response after release until a new transfer.
REQ-041 Push and pop in the same cycle with fifo_count=1 -> count stays 1, resp_valid stays 1, resp_data advances to the new entry.
